// File: rtl/uart_reg_bridge_if.sv
// Byte and register bus signals between uart_reg_bridge (master) and the
// UART byte ports plus register file it talks to (slave).
interface uart_reg_bridge_if #(
   parameter int AW = 8
) ();
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [7:0]    tx_data;
   logic          tx_wr;
   logic          tx_busy;
   logic [AW-1:0] reg_addr;
   logic [7:0]    reg_wdata;
   logic          reg_we;
   logic          reg_re;
   logic [7:0]    reg_rdata;
   logic [7:0]    err_count;

   modport master (
      input  rx_data, rx_valid, tx_busy, reg_rdata,
      output tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, err_count
   );

   modport slave (
      output rx_data, rx_valid, tx_busy, reg_rdata,
      input  tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, err_count
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// Parses 'W' addr data / 'R' addr command frames from the UART receive side,
// drives the register bus and returns one response byte per command.
module uart_reg_bridge #(
   parameter int TIMEOUT = 100_000,
   parameter int AW      = 8
) (
   input logic               clk,
   input logic               rst,
   uart_reg_bridge_if.master bus
);
   localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h3F;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_GET_ADDR  = 4'd1;
   localparam logic [3:0] S_GET_DATA  = 4'd2;
   localparam logic [3:0] S_WRITE     = 4'd3;
   localparam logic [3:0] S_READ      = 4'd4;
   localparam logic [3:0] S_READ_CAP  = 4'd5;
   localparam logic [3:0] S_SEND      = 4'd6;
   localparam logic [3:0] S_SEND_GAP  = 4'd7;
   localparam logic [3:0] S_SEND_WAIT = 4'd8;

   logic [3:0]    state_q, state_d;
   logic          is_write_q, is_write_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          rx_prev_q, rx_prev_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_wr_q, tx_wr_d;
   logic [AW-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]    reg_wdata_q, reg_wdata_d;
   logic          reg_we_q, reg_we_d;
   logic          reg_re_q, reg_re_d;
   logic [7:0]    err_count_q, err_count_d;

   logic accept;
   logic bad_opcode;
   logic timed_out;
   logic overrun;
   logic err_event;

   always_comb begin
      accept      = bus.rx_valid && !rx_prev_q;
      rx_prev_d   = bus.rx_valid;
      state_d     = state_q;
      is_write_d  = is_write_q;
      timer_d     = '0;
      tx_data_d   = tx_data_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      bad_opcode  = 1'b0;
      timed_out   = 1'b0;
      overrun     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                  is_write_d = (bus.rx_data == OP_WRITE);
                  state_d    = S_GET_ADDR;
               end else begin
                  bad_opcode = 1'b1;
                  tx_data_d  = RSP_ERR;
                  state_d    = S_SEND;
               end
            end
         end
         S_GET_ADDR: begin
            if (accept) begin
               reg_addr_d = bus.rx_data[AW-1:0];
               state_d    = is_write_q ? S_GET_DATA : S_READ;
            end else if (timer_q == TIMER_LAST) begin
               timed_out = 1'b1;
               state_d   = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_GET_DATA: begin
            if (accept) begin
               reg_wdata_d = bus.rx_data;
               state_d     = S_WRITE;
            end else if (timer_q == TIMER_LAST) begin
               timed_out = 1'b1;
               state_d   = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WRITE: begin
            tx_data_d = RSP_ACK;
            state_d   = S_SEND;
         end
         S_READ: begin
            state_d = S_READ_CAP;
         end
         S_READ_CAP: begin
            tx_data_d = bus.reg_rdata;
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (tx_wr_q) state_d = S_SEND_GAP;
         end
         S_SEND_GAP: begin
            state_d = S_SEND_WAIT;
         end
         S_SEND_WAIT: begin
            if (!bus.tx_busy) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A byte arriving while a command is executing or its response is in
      // flight cannot be buffered, so it is dropped and counted.
      if (accept && (state_q == S_WRITE || state_q == S_READ || state_q == S_READ_CAP ||
                     state_q == S_SEND || state_q == S_SEND_GAP || state_q == S_SEND_WAIT))
         overrun = 1'b1;

      err_event   = bad_opcode || timed_out || overrun;
      err_count_d = (err_event && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;

      // Strobes look one cycle ahead so they are flops yet line up with the state.
      reg_we_d = (state_d == S_WRITE);
      reg_re_d = (state_d == S_READ);
      tx_wr_d  = (state_d == S_SEND) && !bus.tx_busy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         is_write_q  <= 1'b0;
         timer_q     <= '0;
         rx_prev_q   <= 1'b1;
         tx_data_q   <= 8'h00;
         tx_wr_q     <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= 8'h00;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         err_count_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         is_write_q  <= is_write_d;
         timer_q     <= timer_d;
         rx_prev_q   <= rx_prev_d;
         tx_data_q   <= tx_data_d;
         tx_wr_q     <= tx_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.tx_data   = tx_data_q;
   assign bus.tx_wr     = tx_wr_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_re    = reg_re_q;
   assign bus.err_count = err_count_q;
endmodule
